// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : run_sequencer
//  Purpose  : Host-side run controller for the single-cycle CPU core. For each
//             program it holds the core in reset, presents the program's
//             start PC, releases the core, waits for done and counts the
//             execution cycles. Runs one selected program or all three in
//             order (0 = 3-way multiply, 1 = pattern search, 2 = min pair
//             distance).
//  Ports    :
//    clk           in   system clock, rising edge
//    reset_n       in   asynchronous active-low reset
//    start         in   one-cycle start pulse, honoured only when idle
//    run_all       in   with start: run programs 0,1,2 in succession
//    prog_sel      in   with start (run_all=0): program to run, 3 illegal
//    core_done     in   core done level, meaningful only while running
//    core_reset    out  active-high reset to the core
//    core_start_pc out  start PC presented to the core
//    busy          out  high whenever not idle
//    run_done      out  one-cycle pulse per completed program
//    cur_prog      out  program currently or last run
//    cycle_count   out  run cycles of the current/last program
//    timeout       out  sticky watchdog abort flag
//    prog_err      out  one-cycle pulse on an illegal program select
//  Revision : 1.0 - initial release
// ============================================================================
module run_sequencer #(
    parameter int                PC_W       = 8,
    parameter int                CYC_W      = 16,
    parameter int                RST_CYCLES = 2,
    parameter int unsigned       TIMEOUT    = 32'h0000_FFFF,
    parameter logic [PC_W-1:0]   PROG0_PC   = 8'h00,
    parameter logic [PC_W-1:0]   PROG1_PC   = 8'h40,
    parameter logic [PC_W-1:0]   PROG2_PC   = 8'h80
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               run_all,
    input  logic [1:0]         prog_sel,
    input  logic               core_done,
    output logic               core_reset,
    output logic [PC_W-1:0]    core_start_pc,
    output logic               busy,
    output logic               run_done,
    output logic [1:0]         cur_prog,
    output logic [CYC_W-1:0]   cycle_count,
    output logic               timeout,
    output logic               prog_err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HOLD = 2'd1;
    localparam logic [1:0] c_RUN  = 2'd2;
    localparam logic [1:0] c_NEXT = 2'd3;

    localparam int                   c_HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST = c_HOLD_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0]     c_TIMEOUT   = CYC_W'(TIMEOUT);
    localparam logic [CYC_W-1:0]     c_CNT_MAX   = '1;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_all;
    logic                w_all_nxt;
    logic [1:0]          w_prog_nxt;
    logic [CYC_W-1:0]    w_cnt_inc;
    logic [CYC_W-1:0]    w_cnt_nxt;
    logic                w_timeout_nxt;
    logic                w_illegal;
    logic                w_hold_entry;

    function automatic logic [PC_W-1:0] prog_pc(input logic [1:0] p);
        case (p)
            2'd0:    prog_pc = PROG0_PC;
            2'd1:    prog_pc = PROG1_PC;
            default: prog_pc = PROG2_PC;
        endcase
    endfunction

    // Saturating increment of the run-cycle counter.
    assign w_cnt_inc = (cycle_count == c_CNT_MAX) ? cycle_count : cycle_count + CYC_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_all_nxt     = r_all;
        w_prog_nxt    = cur_prog;
        w_cnt_nxt     = cycle_count;
        w_timeout_nxt = timeout;
        w_illegal     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    if (run_all) begin
                        w_prog_nxt    = 2'd0;
                        w_all_nxt     = 1'b1;
                        w_cnt_nxt     = '0;
                        w_timeout_nxt = 1'b0;
                        w_state_nxt   = c_HOLD;
                    end else if (prog_sel == 2'd3) begin
                        w_illegal     = 1'b1;
                    end else begin
                        w_prog_nxt    = prog_sel;
                        w_all_nxt     = 1'b0;
                        w_cnt_nxt     = '0;
                        w_timeout_nxt = 1'b0;
                        w_state_nxt   = c_HOLD;
                    end
                end
            end
            c_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                // Done wins over the watchdog; the done cycle is not counted.
                if (core_done) begin
                    w_state_nxt = c_NEXT;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_TIMEOUT) begin
                        w_timeout_nxt = 1'b1;
                        w_all_nxt     = 1'b0;
                        w_state_nxt   = c_IDLE;
                    end
                end
            end
            default: begin // c_NEXT
                if (r_all && (cur_prog < 2'd2)) begin
                    w_prog_nxt  = cur_prog + 2'd1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_HOLD;
                end else begin
                    w_all_nxt   = 1'b0;
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    assign w_hold_entry = (w_state_nxt == c_HOLD) && (r_state != c_HOLD);

    // Outputs are registered from the next-state decode so that they line up
    // exactly with the state they describe (core_reset low only in RUN, etc.).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= c_IDLE;
            r_hold_cnt    <= '0;
            r_all         <= 1'b0;
            core_reset    <= 1'b1;
            core_start_pc <= PROG0_PC;
            busy          <= 1'b0;
            run_done      <= 1'b0;
            cur_prog      <= 2'd0;
            cycle_count   <= '0;
            timeout       <= 1'b0;
            prog_err      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_all       <= w_all_nxt;
            cur_prog    <= w_prog_nxt;
            cycle_count <= w_cnt_nxt;
            timeout     <= w_timeout_nxt;
            prog_err    <= w_illegal;
            core_reset  <= (w_state_nxt != c_RUN);
            busy        <= (w_state_nxt != c_IDLE);
            run_done    <= (w_state_nxt == c_NEXT);

            if (w_hold_entry) begin
                r_hold_cnt    <= '0;
                core_start_pc <= prog_pc(w_prog_nxt);
            end else if (r_state == c_HOLD) begin
                r_hold_cnt    <= r_hold_cnt + c_HOLD_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_sequencer
//  Purpose  : Directed self-checking bench for run_sequencer. Acts as host and
//             as a simple core model that raises done on a chosen run cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

    localparam int c_RST_CYC = 2;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        run_all;
    logic [1:0]  prog_sel;
    logic        core_done;
    logic        core_reset;
    logic [7:0]  core_start_pc;
    logic        busy;
    logic        run_done;
    logic [1:0]  cur_prog;
    logic [15:0] cycle_count;
    logic        timeout;
    logic        prog_err;

    int n_checks = 0;
    int n_fail   = 0;

    run_sequencer #(
        .PC_W       (8),
        .CYC_W      (16),
        .RST_CYCLES (c_RST_CYC),
        .TIMEOUT    (20),
        .PROG0_PC   (8'h00),
        .PROG1_PC   (8'h40),
        .PROG2_PC   (8'h80)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .run_all       (run_all),
        .prog_sel      (prog_sel),
        .core_done     (core_done),
        .core_reset    (core_reset),
        .core_start_pc (core_start_pc),
        .busy          (busy),
        .run_done      (run_done),
        .cur_prog      (cur_prog),
        .cycle_count   (cycle_count),
        .timeout       (timeout),
        .prog_err      (prog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first HOLD cycle. The core model keeps done at whatever
    // level it was left, drops it when the core leaves reset, raises it on
    // RUN cycle done_at, and optionally pokes a stray start in RUN cycle 1.
    task automatic do_run(input int done_at, input logic [7:0] exp_pc,
                          input logic [1:0] exp_prog, input bit keep_done,
                          input bit poke);
        for (int h = 0; h < c_RST_CYC; h++) begin
            check("hold_rst",  core_reset,    1);
            check("hold_pc",   core_start_pc, exp_pc);
            check("hold_busy", busy,          1);
            tick();
        end
        core_done = 1'b0;
        check("run_rst",  core_reset,    0);
        check("run_cnt0", cycle_count,   0);
        check("run_pc",   core_start_pc, exp_pc);
        check("run_rdn",  run_done,      0);
        for (int r = 1; r < done_at; r++) begin
            if (poke && r == 1) begin
                start    = 1'b1;
                run_all  = 1'b0;
                prog_sel = 2'd2;
            end
            tick();
            start = 1'b0;
        end
        core_done = 1'b1;
        tick();
        if (!keep_done) core_done = 1'b0;
        check("done_pulse", run_done,    1);
        check("done_cnt",   cycle_count, done_at - 1);
        check("done_prog",  cur_prog,    exp_prog);
        check("done_rst",   core_reset,  1);
        check("done_busy",  busy,        1);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        run_all   = 1'b0;
        prog_sel  = 2'd0;
        core_done = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_core_reset", core_reset,    1);
        check("rst_pc",         core_start_pc, 8'h00);
        check("rst_busy",       busy,          0);
        check("rst_run_done",   run_done,      0);
        check("rst_cur_prog",   cur_prog,      0);
        check("rst_cnt",        cycle_count,   0);
        check("rst_timeout",    timeout,       0);
        check("rst_prog_err",   prog_err,      0);
        reset_n = 1'b1;
        tick();

        // 1. Single run of program 1, done on the 10th run cycle
        start = 1'b1; run_all = 1'b0; prog_sel = 2'd1;
        tick();
        start = 1'b0;
        check("t1_cur_prog", cur_prog, 1);
        do_run(10, 8'h40, 2'd1, 1'b0, 1'b0);
        tick();
        check("t1_busy_fall", busy,        0);
        check("t1_rdn_low",   run_done,    0);
        check("t1_cnt_hold",  cycle_count, 9);
        tick();
        check("t1_idle_rst",  core_reset,  1);

        // 2. Run-all with done after 5/7/3 run cycles
        start = 1'b1; run_all = 1'b1;
        tick();
        start = 1'b0; run_all = 1'b0;
        do_run(5, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        check("t2_gap0_rdn", run_done, 0);
        do_run(7, 8'h40, 2'd1, 1'b0, 1'b0);
        tick();
        check("t2_gap1_rdn", run_done, 0);
        do_run(3, 8'h80, 2'd2, 1'b0, 1'b0);
        tick();
        check("t2_end_busy", busy,        0);
        check("t2_end_rdn",  run_done,    0);
        check("t2_end_cnt",  cycle_count, 2);
        tick();
        check("t2_idle_busy", busy, 0);

        // 3. Watchdog: done never raised, abort after 20 run cycles
        start = 1'b1; prog_sel = 2'd0;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t3_run_rst", core_reset, 0);
        for (int i = 0; i < 19; i++) tick();
        check("t3_cnt19",    cycle_count, 19);
        check("t3_pre_to",   timeout,     0);
        check("t3_pre_rst",  core_reset,  0);
        tick();
        check("t3_timeout",  timeout,     1);
        check("t3_rst",      core_reset,  1);
        check("t3_busy",     busy,        0);
        check("t3_no_rdn",   run_done,    0);
        check("t3_cnt20",    cycle_count, 20);
        tick();
        check("t3_sticky",   timeout,     1);
        check("t3_no_rdn2",  run_done,    0);
        start = 1'b1; prog_sel = 2'd2;
        tick();
        start = 1'b0;
        check("t3_to_clear", timeout, 0);
        do_run(4, 8'h80, 2'd2, 1'b0, 1'b0);
        tick();
        check("t3_end_busy", busy, 0);

        // 4. Illegal program select
        start = 1'b1; prog_sel = 2'd3;
        tick();
        start = 1'b0;
        check("t4_err",      prog_err,    1);
        check("t4_busy",     busy,        0);
        check("t4_rst",      core_reset,  1);
        check("t4_prog",     cur_prog,    2);
        check("t4_cnt",      cycle_count, 3);
        tick();
        check("t4_err_once", prog_err,    0);
        check("t4_busy2",    busy,        0);

        // 5. Stale done through NEXT/HOLD plus a stray start during RUN
        start = 1'b1; run_all = 1'b1; prog_sel = 2'd0;
        tick();
        start = 1'b0; run_all = 1'b0;
        do_run(3, 8'h00, 2'd0, 1'b1, 1'b1);
        tick();
        check("t5_stale_hold", core_done, 1);
        do_run(6, 8'h40, 2'd1, 1'b1, 1'b0);
        tick();
        do_run(3, 8'h80, 2'd2, 1'b1, 1'b0);
        tick();
        core_done = 1'b0;
        check("t5_end_busy", busy,     0);
        check("t5_end_rdn",  run_done, 0);
        check("t5_no_err",   prog_err, 0);

        // 6. Asynchronous reset during program 1 of a run-all
        start = 1'b1; run_all = 1'b1;
        tick();
        start = 1'b0; run_all = 1'b0;
        do_run(2, 8'h00, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        tick();
        check("t6_running",  core_reset, 0);
        check("t6_prog1",    cur_prog,   1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_arst_rst",  core_reset,    1);
        check("t6_arst_busy", busy,          0);
        check("t6_arst_prog", cur_prog,      0);
        check("t6_arst_cnt",  cycle_count,   0);
        check("t6_arst_pc",   core_start_pc, 8'h00);
        check("t6_arst_rdn",  run_done,      0);
        check("t6_arst_to",   timeout,       0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t6_post_busy", busy,       0);
            check("t6_post_rst",  core_reset, 1);
            check("t6_post_rdn",  run_done,   0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
